ccff_bitstream_loader: RTL and testbench
========================================

// Module: ccff_bitstream_loader
// PURPOSE
//  Upstream stage of the configuration-chain (ccff) path. Accepts configuration words over a
//  valid/ready handshake and serialises them onto ccff_head of a ble4/clb configuration chain.
//  ccff_clk_en is the shift strobe for the chain; the clock gate lives outside this block.
//  Loads exactly CHAIN_LEN bits per start, then reports done.
// PARAMETERS
//  CHAIN_LEN  18  bits in the target chain (ble4: 16 LUT4 bits + 2 output-mux bits); must be >= 1
//  DATA_W     8   width of cfg_data words
//  CNT_W      $clog2(CHAIN_LEN+1)  localparam; width of bit_count
// PORTS
//  prog_clk     in   1       configuration clock; only clock in the block
//  prog_reset   in   1       synchronous, active-high reset
//  start        in   1       one-cycle pulse that begins a load; ignored while busy
//  cfg_data     in   DATA_W  configuration word; bit 0 is shifted first
//  cfg_valid    in   1       cfg_data valid
//  cfg_ready    out  1       loader can accept a word
//  ccff_head    out  1       serial bit into the chain head (registered)
//  ccff_clk_en  out  1       chain captures ccff_head on the prog_clk edge where this is 1 (registered)
//  ccff_tail    in   1       chain tail; used only with CCFF_READBACK_EN, ignored otherwise
//  busy         out  1       load in progress
//  done         out  1       load completed; held until next start or reset
//  bit_count    out  CNT_W   bits shifted since last start
// BEHAVIOUR
//  - Reset (edge with prog_reset=1): state IDLE; cfg_ready, ccff_head, ccff_clk_en, busy, done = 0;
//    bit_count = 0. Reset mid-load aborts at once; chain contents are undefined.
//  - States: IDLE -> FETCH -> SHIFT -> (FETCH | DONE); DONE -> FETCH on start.
//  - IDLE/DONE: start=1 -> FETCH next cycle; bit_count := 0, done := 0, busy := 1.
//  - FETCH: cfg_ready=1, ccff_clk_en=0. On cfg_valid&cfg_ready, capture word into the shift register
//    and go to SHIFT. cfg_valid while not in FETCH is never accepted, including start+cfg_valid in
//    the same cycle.
//  - SHIFT: each cycle, ccff_head=shreg[0], ccff_clk_en=1, shift right, bit_count+1.
//    Leave SHIFT when DATA_W bits are sent or bit_count reaches CHAIN_LEN.
//    If bit_count = CHAIN_LEN -> DONE, else -> FETCH.
//  - Timing: word accepted at edge N; its bits are presented on cycles N+1..N+DATA_W;
//    cfg_ready returns on N+DATA_W+1.
//  - Last word: ceil(CHAIN_LEN/DATA_W) words are consumed per load. Unused upper bits of the last
//    word are discarded and never presented.
//  - DONE: busy=0, done=1, ccff_clk_en=0, ccff_head=0, bit_count holds CHAIN_LEN.
//  - Backpressure: while FETCH waits for cfg_valid, ccff_clk_en stays 0 and the chain does not move.
//  - start while busy: ignored; no state change.
//  - First bit shifted ends up at the tail end of the chain after CHAIN_LEN shifts.
// CONFIGURATION
//  CCFF_READBACK_EN defined:
//   - Adds output port rb_crc[15:0].
//   - rb_crc is set to 16'hFFFF on start.
//   - On every cycle with ccff_clk_en=1, the ccff_tail bit (old chain content leaving) is folded
//     into a serial CRC-16-CCITT (poly 0x1021, MSB-first).
//   - rb_crc is final when done=1. Reset value is 16'hFFFF.
//  CCFF_READBACK_EN undefined: rb_crc port absent; ccff_tail unused; no CRC logic.
// TESTING
//  1 Assert prog_reset 2 cycles -> all outputs 0, cfg_ready=0, bit_count=0.
//  2 CHAIN_LEN=18, start, words 0xA5,0x3C,0x02 with cfg_valid always high
//    -> ccff_head = 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 0,1 on the 18 ccff_clk_en=1 cycles;
//    -> exactly 3 words accepted; done=1 and bit_count=18 thereafter.
//  3 As test 2 with cfg_valid low for 5 cycles before each word
//    -> ccff_clk_en low throughout the gaps; bit sequence identical to test 2.
//  4 start pulsed during SHIFT -> ignored, load completes normally.
//    start after done -> second full load, done drops the cycle after start.
//  5 prog_reset asserted on the 5th shift cycle -> next cycle all outputs 0;
//    cfg_valid is then not accepted until a new start.
//  6 CCFF_READBACK_EN: rb_crc=16'hFFFF after start; ccff_tail driven by a bench 18-bit chain model
//    preloaded with 0x2A5C3 -> rb_crc at done equals the bench's CRC-16-CCITT of the outgoing bits.

Source files
------------

// File: rtl/ccff_bitstream_loader.sv
// Serialises cfg_data words onto a configuration chain head, exactly CHAIN_LEN bits per start.
// Optional macro CCFF_READBACK_EN adds rb_crc, a CRC-16-CCITT of the old chain bits leaving ccff_tail.
module ccff_bitstream_loader #(
  parameter  int CHAIN_LEN = 18,
  parameter  int DATA_W    = 8,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count
`ifdef CCFF_READBACK_EN
  ,
  output logic [15:0]       rb_crc
`endif
);

  localparam int WB_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
  localparam logic [WB_W-1:0]  WORD_LAST_C = WB_W'(DATA_W);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [WB_W-1:0]   wbits_q, wbits_d;
  logic [CNT_W-1:0]  bit_count_q, bit_count_d;
  logic              head_q, head_d;
  logic              clk_en_q, clk_en_d;
  logic              chain_full;
  logic              last_bit;

  // wbits_q counts bits of the current word already placed on ccff_head, including this cycle's bit.
  assign chain_full = (bit_count_q + CNT_W'(1)) == CHAIN_LEN_C;
  assign last_bit   = chain_full || (wbits_q == WORD_LAST_C);

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      wbits_q     <= '0;
      bit_count_q <= '0;
      head_q      <= 1'b0;
      clk_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      wbits_q     <= wbits_d;
      bit_count_q <= bit_count_d;
      head_q      <= head_d;
      clk_en_q    <= clk_en_d;
    end
  end

  // head/clk_en are registered, so they are computed for the cycle the FSM is entering.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    wbits_d     = wbits_q;
    bit_count_d = bit_count_q;
    head_d      = 1'b0;
    clk_en_d    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = FETCH;
          bit_count_d = '0;
        end
      end
      FETCH: begin
        if (cfg_valid) begin
          state_d  = SHIFT;
          shreg_d  = cfg_data >> 1;
          wbits_d  = WB_W'(1);
          head_d   = cfg_data[0];
          clk_en_d = 1'b1;
        end
      end
      SHIFT: begin
        bit_count_d = bit_count_q + CNT_W'(1);
        if (last_bit) begin
          state_d = chain_full ? DONE : FETCH;
        end else begin
          shreg_d  = shreg_q >> 1;
          wbits_d  = wbits_q + WB_W'(1);
          head_d   = shreg_q[0];
          clk_en_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      FETCH: begin
        cfg_ready = 1'b1;
        busy      = 1'b1;
      end
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign ccff_head   = head_q;
  assign ccff_clk_en = clk_en_q;
  assign bit_count   = bit_count_q;

`ifdef CCFF_READBACK_EN
  logic [15:0] crc_q, crc_d;
  logic        crc_fb;
  logic        start_ok;

  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));

  // The tail bit is sampled on the same edge the chain shifts, so it is the outgoing old content.
  always_comb begin
    crc_fb = crc_q[15] ^ ccff_tail;
    crc_d  = crc_q;
    if (start_ok) begin
      crc_d = 16'hFFFF;
    end else if (clk_en_q) begin
      crc_d = {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
    end
  end

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      crc_q <= 16'hFFFF;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign rb_crc = crc_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Scoreboard bench for ccff_bitstream_loader: expected chain bits are queued per load and popped on shifts.
// Readback checks are compiled in when CCFF_READBACK_EN is defined.
module tb_ccff_bitstream_loader;
  localparam int CHAIN_LEN = 18;
  localparam int DATA_W    = 8;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam logic [CHAIN_LEN-1:0] PRELOAD = 18'h2A5C3;

  logic                 prog_clk = 1'b0;
  logic                 prog_reset, start, cfg_valid, cfg_ready;
  logic                 ccff_head, ccff_clk_en, ccff_tail, busy, done;
  logic [DATA_W-1:0]    cfg_data;
  logic [CNT_W-1:0]     bit_count;
`ifdef CCFF_READBACK_EN
  logic [15:0]          rb_crc;
  logic [15:0]          crc_after_start;
`endif
  logic [CHAIN_LEN-1:0] chain_m = '0;
  logic                 preload_req;
  logic                 exp_bit;

  int total = 0;
  int bad   = 0;
  bit exp_q[$];
  bit exp_seq[18] = '{1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 0,1};
  logic [7:0] words[4] = '{8'hA5, 8'h3C, 8'h02, 8'hFF};

  always #5 prog_clk = ~prog_clk;

  ccff_bitstream_loader #(.CHAIN_LEN(CHAIN_LEN), .DATA_W(DATA_W)) dut (
    .prog_clk    (prog_clk),
    .prog_reset  (prog_reset),
    .start       (start),
    .cfg_data    (cfg_data),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .ccff_head   (ccff_head),
    .ccff_clk_en (ccff_clk_en),
    .ccff_tail   (ccff_tail),
    .busy        (busy),
    .done        (done),
    .bit_count   (bit_count)
`ifdef CCFF_READBACK_EN
    ,
    .rb_crc      (rb_crc)
`endif
  );

  // Chain model: head enters at bit 0, tail is the top bit.
  always @(posedge prog_clk) begin
    if (preload_req) chain_m <= PRELOAD;
    else if (ccff_clk_en === 1'b1) chain_m <= {chain_m[CHAIN_LEN-2:0], ccff_head};
  end
  assign ccff_tail = chain_m[CHAIN_LEN-1];

  always @(negedge prog_clk) begin
    if (ccff_clk_en === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL shift_extra: head=%0b but no bit expected", ccff_head);
      end else begin
        exp_bit = exp_q.pop_front();
        if (ccff_head !== exp_bit) begin
          bad++;
          $display("FAIL shift_bit: head=%0b expected=%0b", ccff_head, exp_bit);
        end
      end
    end
  end

`ifdef CCFF_READBACK_EN
  function automatic logic [15:0] crc_bit(input logic [15:0] c, input logic b);
    logic fb;
    fb = c[15] ^ b;
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction
`endif

  // Pulses start, feeds words (gap idle cycles before each), optionally pulses start again mid-shift.
  task automatic drive_load(input int gap, input int start_at, output int n_acc, output int gap_en,
                            output int done_c, output int first_en_c,
                            output logic done_at1, output logic [CNT_W-1:0] cnt_at1);
    int g, shifts;
    bit in_gap, mid_sent;
    n_acc = 0; gap_en = 0; done_c = -1; first_en_c = -1;
    done_at1 = 1'bx; cnt_at1 = 'x; g = 0; shifts = 0; mid_sent = 0;
    for (int i = 0; i < CHAIN_LEN; i++) exp_q.push_back(exp_seq[i]);
    for (int c = 0; c < 300 && done_c < 0; c++) begin
      @(posedge prog_clk); #1;
      start = 1'b0;
      if (c == 0) start = 1'b1;
      else if (start_at > 0 && shifts >= start_at && !mid_sent) begin
        start = 1'b1;
        mid_sent = 1;
      end
      in_gap = 0;
      if (gap > 0 && cfg_ready && g < gap) begin
        cfg_valid = 1'b0; g++; in_gap = 1;
      end else if (gap > 0 && !cfg_ready) begin
        cfg_valid = 1'b0;
      end else begin
        cfg_valid = 1'b1;
        cfg_data  = words[n_acc < 3 ? n_acc : 3];
      end
      @(negedge prog_clk);
      if (cfg_valid && cfg_ready) begin n_acc++; g = 0; end
      if (in_gap && ccff_clk_en !== 1'b0) gap_en++;
      if (ccff_clk_en === 1'b1) begin
        shifts++;
        if (first_en_c < 0) first_en_c = c;
      end
      if (c == 1) begin
        done_at1 = done;
        cnt_at1  = bit_count;
`ifdef CCFF_READBACK_EN
        crc_after_start = rb_crc;
`endif
      end
      if (c > 0 && done === 1'b1) done_c = c;
    end
    start = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    int acc;
    prog_reset = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
    repeat (2) @(posedge prog_clk);
    @(negedge prog_clk);
    total++;
    if ({cfg_ready, ccff_head, ccff_clk_en, busy, done} !== 5'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b expected 00000", {cfg_ready, ccff_head, ccff_clk_en, busy, done});
    end
    total++;
    if (bit_count !== '0) begin bad++; $display("FAIL reset_count: got %0d expected 0", bit_count); end
`ifdef CCFF_READBACK_EN
    total++;
    if (rb_crc !== 16'hFFFF) begin bad++; $display("FAIL reset_crc: got %h expected ffff", rb_crc); end
`endif
    @(posedge prog_clk); #1;
    prog_reset = 1'b0;
    cfg_valid = 1'b1; cfg_data = 8'h77;
    acc = 0;
    repeat (3) begin
      @(negedge prog_clk);
      if (cfg_ready !== 1'b0 || ccff_clk_en !== 1'b0) acc++;
      @(posedge prog_clk); #1;
    end
    cfg_valid = 1'b0;
    total++;
    if (acc !== 0) begin bad++; $display("FAIL idle_no_accept: ready/shift cycles=%0d expected 0", acc); end
  endtask

  task automatic test_post_done(input string tag);
    int extra;
    extra = 0;
    cfg_valid = 1'b1; cfg_data = 8'h55;
    repeat (4) begin
      @(posedge prog_clk); #1;
      @(negedge prog_clk);
      if (cfg_valid && cfg_ready) extra++;
    end
    cfg_valid = 1'b0;
    total++;
    if (extra !== 0) begin bad++; $display("FAIL %s_extra_accept: got %0d expected 0", tag, extra); end
    total++;
    if ({done, busy, cfg_ready, ccff_clk_en, ccff_head} !== 5'b10000) begin
      bad++;
      $display("FAIL %s_done_flags: got %b expected 10000", tag, {done, busy, cfg_ready, ccff_clk_en, ccff_head});
    end
    total++;
    if (bit_count !== CNT_W'(18)) begin bad++; $display("FAIL %s_count: got %0d expected 18", tag, bit_count); end
  endtask

  task automatic test_basic();
    int n_acc, gap_en, done_c, first_en_c;
    logic d1;
    logic [CNT_W-1:0] c1;
    drive_load(0, 0, n_acc, gap_en, done_c, first_en_c, d1, c1);
    total++;
    if (n_acc !== 3) begin bad++; $display("FAIL basic_words: got %0d expected 3", n_acc); end
    total++;
    if (first_en_c !== 2) begin bad++; $display("FAIL basic_first_shift: cycle %0d expected 2", first_en_c); end
    total++;
    if (done_c !== 22) begin bad++; $display("FAIL basic_done_cycle: got %0d expected 22", done_c); end
    total++;
    if (d1 !== 1'b0 || c1 !== '0) begin bad++; $display("FAIL basic_after_start: done=%b count=%0d expected 0/0", d1, c1); end
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL basic_bits_left: got %0d expected 0", exp_q.size()); end
    test_post_done("basic");
  endtask

  task automatic test_backpressure();
    int n_acc, gap_en, done_c, first_en_c;
    logic d1;
    logic [CNT_W-1:0] c1;
    drive_load(5, 0, n_acc, gap_en, done_c, first_en_c, d1, c1);
    total++;
    if (n_acc !== 3) begin bad++; $display("FAIL bp_words: got %0d expected 3", n_acc); end
    total++;
    if (gap_en !== 0) begin bad++; $display("FAIL bp_gap_shift: got %0d expected 0", gap_en); end
    total++;
    if (done_c !== 37) begin bad++; $display("FAIL bp_done_cycle: got %0d expected 37", done_c); end
    total++;
    if (exp_q.size() !== 0) begin bad++; $display("FAIL bp_bits_left: got %0d expected 0", exp_q.size()); end
    test_post_done("bp");
  endtask

  task automatic test_start_ignored();
    int n_acc, gap_en, done_c, first_en_c;
    logic d1;
    logic [CNT_W-1:0] c1;
    drive_load(0, 3, n_acc, gap_en, done_c, first_en_c, d1, c1);
    total++;
    if (n_acc !== 3 || done_c !== 22) begin
      bad++;
      $display("FAIL busy_start: words=%0d done_cycle=%0d expected 3/22", n_acc, done_c);
    end
    drive_load(0, 0, n_acc, gap_en, done_c, first_en_c, d1, c1);
    total++;
    if (d1 !== 1'b0) begin bad++; $display("FAIL restart_done_drop: got %b expected 0", d1); end
    total++;
    if (c1 !== '0) begin bad++; $display("FAIL restart_count: got %0d expected 0", c1); end
    total++;
    if (n_acc !== 3 || done_c !== 22 || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL restart_load: words=%0d done_cycle=%0d left=%0d expected 3/22/0", n_acc, done_c, exp_q.size());
    end
  endtask

  task automatic test_reset_abort();
    int n, en_seen, acc, n_acc, gap_en, done_c, first_en_c;
    bit hit;
    logic d1;
    logic [CNT_W-1:0] c1;
    n = 0; en_seen = 0; acc = 0; hit = 0;
    for (int i = 0; i < CHAIN_LEN; i++) exp_q.push_back(exp_seq[i]);
    for (int c = 0; c < 60 && !hit; c++) begin
      @(posedge prog_clk); #1;
      start = (c == 0);
      cfg_valid = 1'b1;
      cfg_data = words[n < 3 ? n : 3];
      if (ccff_clk_en === 1'b1) begin
        en_seen++;
        if (en_seen == 5) begin prog_reset = 1'b1; hit = 1; end
      end
      @(negedge prog_clk);
      if (cfg_valid && cfg_ready) n++;
    end
    @(posedge prog_clk); #1;
    prog_reset = 1'b0; start = 1'b0;
    @(negedge prog_clk);
    total++;
    if (!hit || {cfg_ready, ccff_head, ccff_clk_en, busy, done} !== 5'b0 || bit_count !== '0) begin
      bad++;
      $display("FAIL abort_outputs: hit=%0b got %b count=%0d expected 00000/0", hit,
               {cfg_ready, ccff_head, ccff_clk_en, busy, done}, bit_count);
    end
    total++;
    if (exp_q.size() !== 13) begin bad++; $display("FAIL abort_bits_sent: left=%0d expected 13", exp_q.size()); end
    exp_q.delete();
    repeat (6) begin
      @(posedge prog_clk); #1;
      @(negedge prog_clk);
      if ((cfg_valid && cfg_ready) || ccff_clk_en !== 1'b0) acc++;
    end
    cfg_valid = 1'b0;
    total++;
    if (acc !== 0) begin bad++; $display("FAIL abort_no_accept: got %0d expected 0", acc); end
    drive_load(0, 0, n_acc, gap_en, done_c, first_en_c, d1, c1);
    total++;
    if (n_acc !== 3 || done_c !== 22) begin
      bad++;
      $display("FAIL abort_recover: words=%0d done_cycle=%0d expected 3/22", n_acc, done_c);
    end
  endtask

`ifdef CCFF_READBACK_EN
  task automatic test_readback();
    int n_acc, gap_en, done_c, first_en_c;
    logic d1;
    logic [CNT_W-1:0] c1;
    logic [15:0] exp_crc;
    logic [CHAIN_LEN-1:0] exp_chain;
    @(posedge prog_clk); #1;
    preload_req = 1'b1;
    @(posedge prog_clk); #1;
    preload_req = 1'b0;
    exp_crc = 16'hFFFF;
    for (int i = CHAIN_LEN - 1; i >= 0; i--) exp_crc = crc_bit(exp_crc, PRELOAD[i]);
    for (int i = 0; i < CHAIN_LEN; i++) exp_chain[CHAIN_LEN-1-i] = exp_seq[i];
    drive_load(0, 0, n_acc, gap_en, done_c, first_en_c, d1, c1);
    total++;
    if (crc_after_start !== 16'hFFFF) begin bad++; $display("FAIL rb_crc_start: got %h expected ffff", crc_after_start); end
    total++;
    if (done !== 1'b1 || rb_crc !== exp_crc) begin
      bad++;
      $display("FAIL rb_crc_final: done=%b got %h expected %h", done, rb_crc, exp_crc);
    end
    total++;
    if (chain_m !== exp_chain) begin bad++; $display("FAIL rb_chain: got %h expected %h", chain_m, exp_chain); end
  endtask
`endif

  initial begin
    prog_reset = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_data = '0; preload_req = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_start_ignored();
    test_reset_abort();
`ifdef CCFF_READBACK_EN
    test_readback();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
